immgen_pipe: RTL and testbench

//  Decode-to-execute immediate generator with a registered, back-pressurable output stage.

---
 rtl/immgen_pipe.sv | 122 ++++++++++++
 tb/tb_immgen_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/immgen_pipe.sv
// RISC-V immediate generator with a registered output stage and a one-entry skid buffer.
// Beats carry a TAG_W-bit sideband and can be flushed; downstream may stall at any time.
module immgen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      instr_i,
    input  logic [2:0]       immsrc_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [TAG_W-1:0] tag_o
);

    // Only XLEN of 32 or 64 is meaningful; the decode is built at 64 bits and truncated.
    localparam int unsigned FULL_W = 64;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              sign;
    logic [FULL_W-1:0] imm_wide;
    logic [XLEN-1:0]   imm_c;
    logic [XLEN-1:0]   sr_imm;
    logic [TAG_W-1:0]  sr_tag;
    logic              accept_c;
    logic              drain_c;
    logic              unused_opcode;

    assign unused_opcode = ^instr_i[6:0];
    assign sign          = instr_i[31];

    // Immediate decode for all eight format codes.
    always_comb begin
        imm_wide = '0;
        case (immsrc_i)
            3'b000: imm_wide = {{52{sign}}, instr_i[31:20]};
            3'b001: imm_wide = {{52{sign}}, instr_i[31:25], instr_i[11:7]};
            3'b010: imm_wide = {{51{sign}}, instr_i[31], instr_i[7], instr_i[30:25],
                                instr_i[11:8], 1'b0};
            3'b011: imm_wide = {{43{sign}}, instr_i[31], instr_i[19:12], instr_i[20],
                                instr_i[30:21], 1'b0};
            3'b100: imm_wide = {52'b0, instr_i[31:20]};
            3'b101: imm_wide = (XLEN == 32) ? {59'b0, instr_i[24:20]}
                                            : {58'b0, instr_i[25:20]};
            3'b110: imm_wide = {52'b0, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            3'b111: imm_wide = {{32{sign}}, instr_i[31:12], 12'b0};
            default: imm_wide = '0;
        endcase
        imm_c = XLEN'(imm_wide);
    end

    assign accept_c = valid_i && ready_o && !flush_i;
    assign drain_c  = valid_o && ready_i;

    // Occupancy FSM: OR holds the visible beat, SR catches one beat while OR is stalled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_EMPTY;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            imm_o   <= '0;
            tag_o   <= '0;
            sr_imm  <= '0;
            sr_tag  <= '0;
        end else if (flush_i) begin
            state   <= ST_EMPTY;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept_c) begin
                        imm_o   <= imm_c;
                        tag_o   <= tag_i;
                        valid_o <= 1'b1;
                        state   <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_c && drain_c) begin
                        imm_o <= imm_c;
                        tag_o <= tag_i;
                    end else if (accept_c) begin
                        sr_imm  <= imm_c;
                        sr_tag  <= tag_i;
                        ready_o <= 1'b0;
                        state   <= ST_FULL;
                    end else if (drain_c) begin
                        valid_o <= 1'b0;
                        state   <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so no new beat can arrive alongside the refill.
                    if (drain_c) begin
                        imm_o   <= sr_imm;
                        tag_o   <= sr_tag;
                        ready_o <= 1'b1;
                        state   <= ST_ONE;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_o <= 1'b0;
                    ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed and streaming checks of immgen_pipe at XLEN=32 and XLEN=64 side by side.
module tb_immgen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        valid_in;
    logic [31:0] instr;
    logic [2:0]  immsrc;
    logic [31:0] tag_in;
    logic        ready_in;

    logic        ready32, valid32, ready64, valid64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    immgen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready32),
        .instr_i(instr), .immsrc_i(immsrc), .tag_i(tag_in), .valid_o(valid32),
        .ready_i(ready_in), .imm_o(imm32), .tag_o(tag32)
    );

    immgen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready64),
        .instr_i(instr), .immsrc_i(immsrc), .tag_i(tag_in), .valid_o(valid64),
        .ready_i(ready_in), .imm_o(imm64), .tag_o(tag64)
    );

    // Reference decode using arithmetic shifts of left-aligned fields.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                            input bit x64);
        longint signed t;
        logic [63:0]   r;
        r = '0;
        case (src)
            3'd0: begin t = {ins[31:20], 52'b0}; r = t >>> 52; end
            3'd1: begin t = {ins[31:25], ins[11:7], 52'b0}; r = t >>> 52; end
            3'd2: begin t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 51'b0}; r = t >>> 51; end
            3'd3: begin t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 43'b0}; r = t >>> 43; end
            3'd4: r = 64'(ins[31:20]);
            3'd5: r = x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
            3'd6: r = 64'({ins[7], ins[30:25], ins[11:8], 1'b0});
            default: begin t = {ins[31:12], 44'b0}; r = t >>> 32; end
        endcase
        if (!x64) r = {32'b0, r[31:0]};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; instr = '0; immsrc = '0;
        tag_in = '0; ready_in = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (valid32 !== 1'b0 || valid64 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b/%b exp 0", valid32, valid64); end
        checks++; if (ready32 !== 1'b1 || ready64 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b exp 1", ready32, ready64); end
        checks++; if (imm32 !== 32'h0 || imm64 !== 64'h0) begin errors++; $display("FAIL reset_imm got %h/%h exp 0", imm32, imm64); end
        checks++; if (tag32 !== 32'h0 || tag64 !== 32'h0) begin errors++; $display("FAIL reset_tag got %h/%h exp 0", tag32, tag64); end
    endtask

    task automatic test_decode();
        logic [31:0] vi [13];
        logic [2:0]  vs [13];
        logic [31:0] e32 [13];
        logic [63:0] e64 [13];
        vi[0]  = 32'hFFF00093; vs[0]  = 3'd0; e32[0]  = 32'hFFFFFFFF; e64[0]  = 64'hFFFFFFFFFFFFFFFF;
        vi[1]  = 32'hFE112E23; vs[1]  = 3'd1; e32[1]  = 32'hFFFFFFFC; e64[1]  = 64'hFFFFFFFFFFFFFFFC;
        vi[2]  = 32'hFE112E23; vs[2]  = 3'd4; e32[2]  = 32'h00000FE1; e64[2]  = 64'h0000000000000FE1;
        vi[3]  = 32'hFE112E23; vs[3]  = 3'd5; e32[3]  = 32'h00000001; e64[3]  = 64'h0000000000000021;
        vi[4]  = 32'h800000B7; vs[4]  = 3'd7; e32[4]  = 32'h80000000; e64[4]  = 64'hFFFFFFFF80000000;
        vi[5]  = 32'h03F00013; vs[5]  = 3'd5; e32[5]  = 32'h0000001F; e64[5]  = 64'h000000000000003F;
        vi[6]  = 32'h80000063; vs[6]  = 3'd2; e32[6]  = 32'hFFFFF000; e64[6]  = 64'hFFFFFFFFFFFFF000;
        vi[7]  = 32'hFE000FE3; vs[7]  = 3'd2; e32[7]  = 32'hFFFFFFFE; e64[7]  = 64'hFFFFFFFFFFFFFFFE;
        vi[8]  = 32'hFE000FE3; vs[8]  = 3'd6; e32[8]  = 32'h00000FFE; e64[8]  = 64'h0000000000000FFE;
        vi[9]  = 32'h7FFFF06F; vs[9]  = 3'd3; e32[9]  = 32'h000FFFFE; e64[9]  = 64'h00000000000FFFFE;
        vi[10] = 32'h8000006F; vs[10] = 3'd3; e32[10] = 32'hFFF00000; e64[10] = 64'hFFFFFFFFFFF00000;
        vi[11] = 32'h12345037; vs[11] = 3'd7; e32[11] = 32'h12345000; e64[11] = 64'h0000000012345000;
        vi[12] = 32'h7FF00013; vs[12] = 3'd0; e32[12] = 32'h000007FF; e64[12] = 64'h00000000000007FF;
        ready_in = 1'b1;
        for (int i = 0; i < 13; i++) begin
            valid_in = 1'b1; instr = vi[i]; immsrc = vs[i]; tag_in = 32'(i + 100);
            tick();
            valid_in = 1'b0;
            checks++; if (valid32 !== 1'b1 || valid64 !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d] got %b/%b exp 1", i, valid32, valid64); end
            checks++; if (imm32 !== e32[i]) begin errors++; $display("FAIL dec_imm32[%0d] got %h exp %h", i, imm32, e32[i]); end
            checks++; if (imm64 !== e64[i]) begin errors++; $display("FAIL dec_imm64[%0d] got %h exp %h", i, imm64, e64[i]); end
            checks++; if (tag32 !== 32'(i + 100)) begin errors++; $display("FAIL dec_tag[%0d] got %0d exp %0d", i, tag32, i + 100); end
            tick();
            checks++; if (valid32 !== 1'b0) begin errors++; $display("FAIL dec_drain[%0d] got %b exp 0", i, valid32); end
        end
    endtask

    task automatic test_backpressure();
        ready_in = 1'b0; instr = 32'h00100093; immsrc = 3'd0;
        valid_in = 1'b1; tag_in = 32'd1;
        tick();
        checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL bp_ready_one got %b exp 1", ready32); end
        tag_in = 32'd2;
        tick();
        valid_in = 1'b0;
        checks++; if (ready32 !== 1'b0 || ready64 !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b/%b exp 0", ready32, ready64); end
        checks++; if (valid32 !== 1'b1 || tag32 !== 32'd1) begin errors++; $display("FAIL bp_head got v=%b tag=%0d exp v=1 tag=1", valid32, tag32); end
        tick();
        checks++; if (valid32 !== 1'b1 || tag32 !== 32'd1 || imm32 !== 32'd1) begin errors++; $display("FAIL bp_hold got v=%b tag=%0d imm=%h exp 1/1/1", valid32, tag32, imm32); end
        ready_in = 1'b1;
        tick();
        checks++; if (valid32 !== 1'b1 || tag32 !== 32'd2) begin errors++; $display("FAIL bp_second got v=%b tag=%0d exp v=1 tag=2", valid32, tag32); end
        checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", ready32); end
        tick();
        checks++; if (valid32 !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", valid32); end
    endtask

    task automatic test_stream();
        logic [63:0] q_i64 [$];
        logic [31:0] q_i32 [$];
        logic [31:0] q_tag [$];
        int pushed = 0, popped = 0, cyc = 0;
        bit acc, drn;
        while (popped < 100 && cyc < 3000) begin
            valid_in = (pushed < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            ready_in = 1'($urandom_range(0, 2) != 0);
            instr = $urandom; immsrc = 3'($urandom_range(0, 7)); tag_in = 32'(pushed + 1000);
            #1;
            checks++; if (valid32 !== (q_tag.size() > 0) || valid64 !== (q_tag.size() > 0)) begin errors++; $display("FAIL st_valid cyc %0d got %b/%b exp %b", cyc, valid32, valid64, q_tag.size() > 0); end
            checks++; if (ready32 !== (q_tag.size() < 2) || ready64 !== (q_tag.size() < 2)) begin errors++; $display("FAIL st_ready cyc %0d got %b/%b exp %b", cyc, ready32, ready64, q_tag.size() < 2); end
            if (q_tag.size() > 0) begin
                checks++; if (tag32 !== q_tag[0] || tag64 !== q_tag[0]) begin errors++; $display("FAIL st_tag cyc %0d got %0d/%0d exp %0d", cyc, tag32, tag64, q_tag[0]); end
                checks++; if (imm32 !== q_i32[0] || imm64 !== q_i64[0]) begin errors++; $display("FAIL st_imm cyc %0d got %h/%h exp %h/%h", cyc, imm32, imm64, q_i32[0], q_i64[0]); end
            end
            acc = valid_in && (q_tag.size() < 2);
            drn = (q_tag.size() > 0) && ready_in;
            if (acc) begin
                q_i32.push_back(32'(ref_imm(instr, immsrc, 1'b0)));
                q_i64.push_back(ref_imm(instr, immsrc, 1'b1));
                q_tag.push_back(tag_in);
            end
            tick();
            if (drn) begin
                void'(q_i32.pop_front()); void'(q_i64.pop_front()); void'(q_tag.pop_front());
                popped++;
            end
            if (acc) pushed++;
            cyc++;
        end
        valid_in = 1'b0;
        checks++; if (popped != 100) begin errors++; $display("FAIL st_done got %0d beats exp 100", popped); end
    endtask

    task automatic fill_full();
        ready_in = 1'b0; valid_in = 1'b1; immsrc = 3'd0; instr = 32'h00500093;
        tag_in = 32'hAA; tick();
        tag_in = 32'hBB; tick();
        checks++; if (ready32 !== 1'b0 || valid32 !== 1'b1) begin errors++; $display("FAIL fill_full got r=%b v=%b exp r=0 v=1", ready32, valid32); end
    endtask

    task automatic test_flush();
        fill_full();
        flush = 1'b1; valid_in = 1'b1; tag_in = 32'hCC;
        tick();
        flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        checks++; if (valid32 !== 1'b0 || valid64 !== 1'b0) begin errors++; $display("FAIL fl_valid got %b/%b exp 0", valid32, valid64); end
        checks++; if (ready32 !== 1'b1 || ready64 !== 1'b1) begin errors++; $display("FAIL fl_ready got %b/%b exp 1", ready32, ready64); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (valid32 !== 1'b0 || valid64 !== 1'b0) begin errors++; $display("FAIL fl_quiet[%0d] got %b/%b exp 0", i, valid32, valid64); end
        end
    endtask

    task automatic test_reset_mid();
        fill_full();
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid32 !== 1'b0 || ready32 !== 1'b1 || valid64 !== 1'b0 || ready64 !== 1'b1) begin errors++; $display("FAIL rst_mid_ctl got v=%b r=%b exp v=0 r=1", valid32, ready32); end
        checks++; if (imm32 !== 32'h0 || tag32 !== 32'h0 || imm64 !== 64'h0 || tag64 !== 32'h0) begin errors++; $display("FAIL rst_mid_data got imm=%h tag=%h exp 0", imm32, tag32); end
        tick();
        rst_n = 1'b1; ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid32 !== 1'b0 || valid64 !== 1'b0) begin errors++; $display("FAIL rst_quiet[%0d] got %b/%b exp 0", i, valid32, valid64); end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_stream();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
